// File: rtl/redmule_pkg.sv
// Shared constants for the RedMulE TCDM path: narrow lane geometry and a
// small helper to size counters that must hold the value N itself.
package redmule_pkg;

    localparam int unsigned TcdmLaneW  = 32;  // bits per narrow TCDM lane
    localparam int unsigned TcdmLaneBw = 4;   // byte enables per narrow lane

    // Width needed to represent 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/redmule_lane_fifo.sv
// Per-lane response FIFO. The head word is readable combinationally so a
// response stored on one edge can leave the splitter in the next cycle.
// A push while full or a pop while empty is ignored; the splitter flags
// the overflow case itself.
module redmule_lane_fifo
    import redmule_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = cnt_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and fill level; clear wins over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide TCDM request into MP narrow 32-bit requests. Lane grants
// are collected over several cycles in done_q; responses are realigned
// through one FIFO per lane and released only when every lane has data.
// A credit counter keeps outstanding wide transactions within FIFO depth.
module redmule_tcdm_splitter
    import redmule_pkg::*;
#(
    parameter int unsigned MP             = 4,
    parameter int unsigned AW             = 32,
    parameter int unsigned RespDepth      = 4,
    parameter bit          SkipEmptyLanes = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [AW-1:0]             add_i,
    input  logic                      wen_i,
    input  logic [MP*TcdmLaneBw-1:0]  be_i,
    input  logic [MP*TcdmLaneW-1:0]   data_i,
    output logic [MP*TcdmLaneW-1:0]   r_data_o,
    output logic                      r_valid_o,
    output logic [MP-1:0]             tcdm_req_o,
    input  logic [MP-1:0]             tcdm_gnt_i,
    output logic [MP*AW-1:0]          tcdm_add_o,
    output logic [MP-1:0]             tcdm_wen_o,
    output logic [MP*TcdmLaneBw-1:0]  tcdm_be_o,
    output logic [MP*TcdmLaneW-1:0]   tcdm_data_o,
    input  logic [MP*TcdmLaneW-1:0]   tcdm_r_data_i,
    input  logic [MP-1:0]             tcdm_r_valid_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned CntW = cnt_width(RespDepth);
    localparam int unsigned LW   = TcdmLaneW;
    localparam int unsigned LB   = TcdmLaneBw;

    logic [MP-1:0]   done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [MP-1:0]   skip, lane_req, lane_sat, lane_err;
    logic [MP-1:0]   fifo_push, fifo_empty, fifo_full;
    logic [LW-1:0]   fifo_wdata [MP];
    logic [LW-1:0]   fifo_head  [MP];
    logic            credit_ok, gnt_int, rvalid_int, busy_int;

    // Credit check uses only the registered count, never a same-cycle pop.
    assign credit_ok  = (cnt_q < CntW'(RespDepth));
    assign gnt_int    = req_i & credit_ok & (&lane_sat);
    assign rvalid_int = ~(|fifo_empty);
    assign busy_int   = (cnt_q != '0) | (|done_q);

    // Every output is forced low while reset is held, including the
    // purely combinational lane mapping.
    assign gnt_o     = gnt_int & ~rst_i;
    assign r_valid_o = rvalid_int & ~rst_i;
    assign busy_o    = busy_int & ~rst_i;
    assign err_o     = err_q & ~rst_i;

    for (genvar gi = 0; gi < MP; gi++) begin : g_lane
        logic narrow_push, skip_push;

        assign skip[gi]     = SkipEmptyLanes & ~wen_i & (be_i[gi*LB +: LB] == '0);
        assign lane_req[gi] = req_i & credit_ok & ~done_q[gi] & ~skip[gi];
        assign lane_sat[gi] = done_q[gi] | skip[gi] | (lane_req[gi] & tcdm_gnt_i[gi]);

        // Responses into a full FIFO or with nothing outstanding are dropped.
        assign lane_err[gi] = tcdm_r_valid_i[gi] & (fifo_full[gi] | (cnt_q == '0));
        assign narrow_push  = tcdm_r_valid_i[gi] & ~lane_err[gi];
        // Skipped lanes get a zero entry so the wide response aligns.
        assign skip_push    = gnt_int & skip[gi];

        assign fifo_push[gi]  = narrow_push | skip_push;
        assign fifo_wdata[gi] = skip_push ? '0 : tcdm_r_data_i[gi*LW +: LW];

        redmule_lane_fifo #(
            .Depth (RespDepth),
            .Width (LW)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (fifo_push[gi]),
            .data_i  (fifo_wdata[gi]),
            .pop_i   (rvalid_int),
            .data_o  (fifo_head[gi]),
            .empty_o (fifo_empty[gi]),
            .full_o  (fifo_full[gi])
        );

        assign tcdm_req_o[gi]             = lane_req[gi] & ~rst_i;
        assign tcdm_add_o[gi*AW +: AW]    = rst_i ? '0 : add_i + AW'(LB * gi);
        assign tcdm_wen_o[gi]             = wen_i & ~rst_i;
        assign tcdm_be_o[gi*LB +: LB]     = rst_i ? '0 : be_i[gi*LB +: LB];
        assign tcdm_data_o[gi*LW +: LW]   = rst_i ? '0 : data_i[gi*LW +: LW];
        // Read data is zero outside valid cycles so stale heads never leak.
        assign r_data_o[gi*LW +: LW]      = (rvalid_int & ~rst_i) ? fifo_head[gi] : '0;
    end

    // Next-state for grant tracking, credits and the sticky error.
    always_comb begin
        done_d = done_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (|lane_err);
        if (gnt_int) done_d = '0;
        else         done_d = done_q | (lane_req & tcdm_gnt_i);
        case ({gnt_int, rvalid_int})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            done_d = '0;
            cnt_d  = '0;
            // Clearing with work in flight leaves a marker: late responses
            // can no longer be matched.
            err_d  = busy_int;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter with MP=4, RespDepth=2.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_redmule_tcdm_splitter;

    localparam int unsigned MP = 4;
    localparam int unsigned AW = 32;

    logic              clk = 1'b0;
    logic              rst_i, clear_i, req_i, wen_i;
    logic [AW-1:0]     add_i;
    logic [MP*4-1:0]   be_i;
    logic [MP*32-1:0]  data_i, tcdm_r_data_i;
    logic [MP-1:0]     tcdm_gnt_i, tcdm_r_valid_i;
    logic              gnt_o, r_valid_o, busy_o, err_o;
    logic [MP*32-1:0]  r_data_o, tcdm_data_o;
    logic [MP-1:0]     tcdm_req_o, tcdm_wen_o;
    logic [MP*AW-1:0]  tcdm_add_o;
    logic [MP*4-1:0]   tcdm_be_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    redmule_tcdm_splitter #(
        .MP (MP), .AW (AW), .RespDepth (2), .SkipEmptyLanes (1'b1)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .clear_i (clear_i),
        .req_i (req_i), .gnt_o (gnt_o), .add_i (add_i), .wen_i (wen_i),
        .be_i (be_i), .data_i (data_i), .r_data_o (r_data_o),
        .r_valid_o (r_valid_o), .tcdm_req_o (tcdm_req_o),
        .tcdm_gnt_i (tcdm_gnt_i), .tcdm_add_o (tcdm_add_o),
        .tcdm_wen_o (tcdm_wen_o), .tcdm_be_o (tcdm_be_o),
        .tcdm_data_o (tcdm_data_o), .tcdm_r_data_i (tcdm_r_data_i),
        .tcdm_r_valid_i (tcdm_r_valid_i), .busy_o (busy_o), .err_o (err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; req_i = 1'b1; wen_i = 1'b1;
        add_i = 32'h1234; be_i = 16'hFFFF; data_i = '1;
        tcdm_gnt_i = 4'hF; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
        #2;
        chk("rst_gnt",  128'(gnt_o), 128'd0);
        chk("rst_req",  128'(tcdm_req_o), 128'd0);
        chk("rst_add",  128'(tcdm_add_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        step();
        rst_i = 1'b0; req_i = 1'b0; add_i = '0; data_i = '0;
        step();

        // 1: all lanes grant at once, aligned responses
        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1000; tcdm_gnt_i = 4'hF;
        #1;
        chk("t1_gnt", 128'(gnt_o), 128'd1);
        chk("t1_req", 128'(tcdm_req_o), 128'hF);
        chk("t1_add", 128'(tcdm_add_o), 128'h0000100C_00001008_00001004_00001000);
        chk("t1_wen", 128'(tcdm_wen_o), 128'hF);
        step();
        req_i = 1'b0;
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        #1;
        chk("t1_busy",   128'(busy_o), 128'd1);
        chk("t1_rv_early", 128'(r_valid_o), 128'd0);
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t1_rv",    128'(r_valid_o), 128'd1);
        chk("t1_rdata", 128'(r_data_o), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        step();
        chk("t1_rv_off", 128'(r_valid_o), 128'd0);
        chk("t1_idle",   128'(busy_o), 128'd0);

        // 2: staggered grants
        req_i = 1'b1; add_i = 32'h2000; tcdm_gnt_i = 4'b0001;
        #1;
        chk("t2_c0_req", 128'(tcdm_req_o), 128'hF);
        chk("t2_c0_gnt", 128'(gnt_o), 128'd0);
        step();
        tcdm_gnt_i = 4'b0000;
        #1;
        chk("t2_c1_req",  128'(tcdm_req_o), 128'hE);
        chk("t2_c1_gnt",  128'(gnt_o), 128'd0);
        chk("t2_c1_busy", 128'(busy_o), 128'd1);
        step();
        tcdm_gnt_i = 4'hE;
        #1;
        chk("t2_c2_gnt", 128'(gnt_o), 128'd1);
        chk("t2_c2_req", 128'(tcdm_req_o), 128'hE);
        step();
        req_i = 1'b0; tcdm_gnt_i = 4'hF;

        // 3: staggered responses to the transaction from step 2
        tcdm_r_valid_i = 4'b0111;
        tcdm_r_data_i = {32'hFFFF, 32'hB2, 32'hB1, 32'hB0};
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t3_t1_rv", 128'(r_valid_o), 128'd0);
        step();
        chk("t3_t2_rv", 128'(r_valid_o), 128'd0);
        step();
        tcdm_r_valid_i = 4'b1000;
        tcdm_r_data_i = {32'hB3, 32'h0, 32'h0, 32'h0};
        #1;
        chk("t3_t3_rv", 128'(r_valid_o), 128'd0);
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t3_t4_rv",    128'(r_valid_o), 128'd1);
        chk("t3_t4_rdata", 128'(r_data_o), {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        step();
        chk("t3_t5_rv",   128'(r_valid_o), 128'd0);
        chk("t3_t5_busy", 128'(busy_o), 128'd0);

        // 4: credit limit of two outstanding reads
        req_i = 1'b1; add_i = 32'h3000;
        #1;
        chk("t4_g1", 128'(gnt_o), 128'd1);
        step();
        add_i = 32'h3010;
        #1;
        chk("t4_g2", 128'(gnt_o), 128'd1);
        step();
        add_i = 32'h3020;
        #1;
        chk("t4_hold_gnt", 128'(gnt_o), 128'd0);
        chk("t4_hold_req", 128'(tcdm_req_o), 128'h0);
        step();
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        #1;
        chk("t4_hold2_gnt", 128'(gnt_o), 128'd0);
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t4_pop_rv",    128'(r_valid_o), 128'd1);
        chk("t4_pop_rdata", 128'(r_data_o), {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        chk("t4_pop_gnt",   128'(gnt_o), 128'd0);
        step();
        chk("t4_g3", 128'(gnt_o), 128'd1);
        chk("t4_g3_add", 128'(tcdm_add_o), 128'h0000302C_00003028_00003024_00003020);
        step();
        req_i = 1'b0;
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        step();
        tcdm_r_data_i = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        #1;
        chk("t4_d", 128'(r_data_o), {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t4_e", 128'(r_data_o), {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        step();
        chk("t4_idle", 128'(busy_o), 128'd0);

        // 5: write with only lane 1 enabled
        req_i = 1'b1; wen_i = 1'b0; add_i = 32'h4000; be_i = 16'h00F0;
        data_i = {32'h33, 32'h22, 32'h11, 32'h00};
        #1;
        chk("t5_req",  128'(tcdm_req_o), 128'h2);
        chk("t5_gnt",  128'(gnt_o), 128'd1);
        chk("t5_be",   128'(tcdm_be_o), 128'h00F0);
        chk("t5_wen",  128'(tcdm_wen_o), 128'h0);
        chk("t5_data", 128'(tcdm_data_o), {32'h33, 32'h22, 32'h11, 32'h00});
        step();
        req_i = 1'b0; wen_i = 1'b1; be_i = 16'hFFFF;
        #1;
        chk("t5_rv_wait", 128'(r_valid_o), 128'd0);
        tcdm_r_valid_i = 4'b0010;
        tcdm_r_data_i = {32'hFF, 32'hFF, 32'h55, 32'hFF};
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t5_rv",    128'(r_valid_o), 128'd1);
        chk("t5_rdata", 128'(r_data_o), {32'h0, 32'h0, 32'h55, 32'h0});
        step();
        chk("t5_idle", 128'(busy_o), 128'd0);

        // 6: spurious response, clear, clear while busy, reset mid-flight
        tcdm_r_valid_i = 4'b0100;
        step();
        tcdm_r_valid_i = '0;
        #1;
        chk("t6_err",     128'(err_o), 128'd1);
        chk("t6_dropped", 128'(r_valid_o), 128'd0);
        step();
        chk("t6_sticky", 128'(err_o), 128'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        #1;
        chk("t6_clr", 128'(err_o), 128'd0);
        req_i = 1'b1; add_i = 32'h4800; tcdm_gnt_i = 4'b0001;
        step();
        req_i = 1'b0; tcdm_gnt_i = 4'h0;
        #1;
        chk("t6_busy", 128'(busy_o), 128'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        #1;
        chk("t6_clr_busy_err", 128'(err_o), 128'd1);
        chk("t6_clr_busy",     128'(busy_o), 128'd0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        req_i = 1'b1; add_i = 32'h5000; tcdm_gnt_i = 4'hF;
        step();
        add_i = 32'h5010; tcdm_gnt_i = 4'h0;
        #1;
        chk("t6_pre_busy", 128'(busy_o), 128'd1);
        chk("t6_pre_req",  128'(tcdm_req_o), 128'hF);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_req",  128'(tcdm_req_o), 128'h0);
        chk("t6_rst_add",  128'(tcdm_add_o), 128'h0);
        chk("t6_rst_busy", 128'(busy_o), 128'd0);
        chk("t6_rst_gnt",  128'(gnt_o), 128'd0);
        step();
        rst_i = 1'b0; req_i = 1'b0;
        step();
        chk("t6_post_busy", 128'(busy_o), 128'd0);
        chk("t6_post_err",  128'(err_o), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
